cfg_loader: RTL and testbench

//  Configuration-chain master. Takes bitstream bytes over a valid/ready stream.

---
 rtl/cfg_loader.sv | 187 ++++++++++++++++++
 tb/tb_cfg_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_loader.sv
// cfg_loader: configuration-chain master. Serialises bitstream bytes onto
// prog_clk/prog_en/prog_in and collects the bits pushed out of the chain tail
// on prog_out into readback bytes.
module cfg_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       prog_clk,
  output logic       prog_en,
  output logic       prog_in,
  input  logic       prog_out
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int DW = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_FINISH,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          prog_en_q, prog_en_d;
  logic          prog_clk_q, prog_clk_d;
  logic          prog_in_q, prog_in_d;
  logic [7:0]    data_q, data_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bits_done_q, bits_done_d;
  logic [7:0]    rb_q, rb_d;
  logic [2:0]    rb_cnt_q, rb_cnt_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;

  logic          div_last;
  assign div_last = (div_q == DW'(CLK_DIV - 1));

  assign busy      = busy_q;
  assign prog_en   = prog_en_q;
  assign prog_clk  = prog_clk_q;
  assign prog_in   = prog_in_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  // State and datapath registers with synchronous reset (reset aborts a load).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      prog_en_q   <= 1'b0;
      prog_clk_q  <= 1'b0;
      prog_in_q   <= 1'b0;
      data_q      <= '0;
      bit_idx_q   <= '0;
      div_q       <= '0;
      bits_done_q <= '0;
      rb_q        <= '0;
      rb_cnt_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      prog_en_q   <= prog_en_d;
      prog_clk_q  <= prog_clk_d;
      prog_in_q   <= prog_in_d;
      data_q      <= data_d;
      bit_idx_q   <= bit_idx_d;
      div_q       <= div_d;
      bits_done_q <= bits_done_d;
      rb_q        <= rb_d;
      rb_cnt_q    <= rb_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, shift sequencing and readback capture.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    prog_en_d   = prog_en_q;
    prog_clk_d  = prog_clk_q;
    prog_in_d   = prog_in_q;
    data_d      = data_q;
    bit_idx_d   = bit_idx_q;
    div_d       = div_q;
    bits_done_d = bits_done_q;
    rb_d        = rb_q;
    rb_cnt_d    = rb_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    in_ready    = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD;
          busy_d      = 1'b1;
          prog_en_d   = 1'b1;
          prog_clk_d  = 1'b0;
          bits_done_d = '0;
          rb_cnt_d    = '0;
          div_d       = '0;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d    = in_data;
          prog_in_d = in_data[7];
          bit_idx_d = 3'd7;
          div_d     = '0;
          state_d   = S_SHIFT_LO;
        end
      end
      S_SHIFT_LO: begin
        if (div_last) begin
          // The edge that raises prog_clk also samples the pre-shift tail bit.
          div_d       = '0;
          prog_clk_d  = 1'b1;
          state_d     = S_SHIFT_HI;
          bits_done_d = bits_done_q + BW'(1);
          rb_d        = {rb_q[6:0], prog_out};
          rb_cnt_d    = rb_cnt_q + 3'd1;
          if (rb_cnt_q == 3'd7) begin
            out_data_d  = {rb_q[6:0], prog_out};
            out_valid_d = 1'b1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_SHIFT_HI: begin
        if (div_last) begin
          div_d      = '0;
          prog_clk_d = 1'b0;
          if (bits_done_q == BW'(CHAIN_LEN)) begin
            state_d = S_FINISH;
            // Trailing partial byte: left-justify so padding lands in the LSBs.
            if (rb_cnt_q != 3'd0) begin
              out_data_d  = rb_q << (4'd8 - {1'b0, rb_cnt_q});
              out_valid_d = 1'b1;
            end
          end else if (bit_idx_q == 3'd0) begin
            state_d = S_LOAD;
          end else begin
            bit_idx_d = bit_idx_q - 3'd1;
            prog_in_d = data_q[6];
            data_d    = {data_q[6:0], 1'b0};
            state_d   = S_SHIFT_LO;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_FINISH: begin
        prog_clk_d = 1'b0;
        state_d    = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        prog_en_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: directed bench with behavioural config chains for two
// loader instances (16-bit chain / CLK_DIV=1 and 12-bit chain / CLK_DIV=3).
`timescale 1ns/1ps
module tb_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       start_s = 1'b0;
  logic       in_valid_s = 1'b0;
  logic [7:0] in_data_s = 8'h00;

  int n_chk = 0;
  int n_pass = 0;

  // Instance A: CHAIN_LEN=16, CLK_DIV=1
  logic       a_start, a_busy, a_done, a_in_valid, a_in_ready, a_out_valid;
  logic       a_prog_clk, a_prog_en, a_prog_in, a_prog_out;
  logic [7:0] a_out_data;
  assign a_start    = start_s & ~sel;
  assign a_in_valid = in_valid_s & ~sel;

  cfg_loader #(.CHAIN_LEN(16), .CLK_DIV(1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .in_data(in_data_s), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .prog_clk(a_prog_clk),
    .prog_en(a_prog_en), .prog_in(a_prog_in), .prog_out(a_prog_out)
  );

  // Instance B: CHAIN_LEN=12, CLK_DIV=3
  logic       b_start, b_busy, b_done, b_in_valid, b_in_ready, b_out_valid;
  logic       b_prog_clk, b_prog_en, b_prog_in, b_prog_out;
  logic [7:0] b_out_data;
  assign b_start    = start_s & sel;
  assign b_in_valid = in_valid_s & sel;

  cfg_loader #(.CHAIN_LEN(12), .CLK_DIV(3)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .in_data(in_data_s), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .prog_clk(b_prog_clk),
    .prog_en(b_prog_en), .prog_in(b_prog_in), .prog_out(b_prog_out)
  );

  // Behavioural chains: bit 0 is the head, MSB is the tail.
  logic [15:0] a_chain = 16'h0000, a_pre_val = 16'h0000;
  logic [11:0] b_chain = 12'h000,  b_pre_val = 12'h000;
  logic        a_pre = 1'b0, b_pre = 1'b0;
  int a_rises = 0, b_rises = 0, a_bad_en = 0, b_bad_en = 0;
  longint b_rt[$];
  assign a_prog_out = a_chain[15];
  assign b_prog_out = b_chain[11];

  always @(posedge a_prog_clk or posedge a_pre) begin
    if (a_pre) a_chain <= a_pre_val;
    else begin
      a_rises <= a_rises + 1;
      if (!a_prog_en) a_bad_en <= a_bad_en + 1;
      else a_chain <= {a_chain[14:0], a_prog_in};
    end
  end

  always @(posedge b_prog_clk or posedge b_pre) begin
    if (b_pre) b_chain <= b_pre_val;
    else begin
      b_rises <= b_rises + 1;
      b_rt.push_back($time);
      if (!b_prog_en) b_bad_en <= b_bad_en + 1;
      else b_chain <= {b_chain[10:0], b_prog_in};
    end
  end

  // Done pulses, readback bytes and accepted input bytes per instance.
  int a_done_n = 0, b_done_n = 0, a_acc = 0, b_acc = 0;
  logic [7:0] a_rbq[$], b_rbq[$];
  always @(posedge clk) begin
    if (a_done) a_done_n <= a_done_n + 1;
    if (b_done) b_done_n <= b_done_n + 1;
    if (a_out_valid) a_rbq.push_back(a_out_data);
    if (b_out_valid) b_rbq.push_back(b_out_data);
    if (a_in_valid && a_in_ready) a_acc <= a_acc + 1;
    if (b_in_valid && b_in_ready) b_acc <= b_acc + 1;
  end

  // prog_in timing watch on B: changes only with prog_clk low, held >=3 cycles before a rise.
  logic b_last_in = 1'b0, b_last_clk = 1'b0;
  int   b_stable = 0, b_viol = 0;
  always @(posedge clk) begin
    if (b_prog_in != b_last_in) begin
      if (b_prog_clk != 1'b0) b_viol <= b_viol + 1;
      b_stable <= 1;
    end else begin
      if (b_prog_clk && !b_last_clk && b_stable < 3) b_viol <= b_viol + 1;
      b_stable <= b_stable + 1;
    end
    b_last_in  <= b_prog_in;
    b_last_clk <= b_prog_clk;
  end

  // Views of whichever instance sel points at.
  logic in_ready_s, busy_s, en_s, pclk_s;
  int   done_s, rises_s;
  assign in_ready_s = sel ? b_in_ready : a_in_ready;
  assign busy_s     = sel ? b_busy : a_busy;
  assign en_s       = sel ? b_prog_en : a_prog_en;
  assign pclk_s     = sel ? b_prog_clk : a_prog_clk;
  assign done_s     = sel ? b_done_n : a_done_n;
  assign rises_s    = sel ? b_rises : a_rises;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic preload_a(input logic [15:0] v);
    a_pre_val = v; a_pre = 1'b1; #1 a_pre = 1'b0;
  endtask

  task automatic preload_b(input logic [11:0] v);
    b_pre_val = v; b_pre = 1'b1; #1 b_pre = 1'b0;
  endtask

  // One full load of two bytes; optional stall (in_valid low) before byte 2.
  task automatic run_load(input logic [7:0] b0, input logic [7:0] b1, input int stall);
    int d0, k, r0, bad;
    d0 = done_s;
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    check("busy_en_after_start", {busy_s, en_s}, 2'b11);
    for (int i = 0; i < 2; i++) begin
      if (i == 1 && stall > 0) begin
        in_valid_s = 1'b0;
        k = 0;
        while (!in_ready_s && k < 200) begin @(negedge clk); k++; end
        r0 = rises_s; bad = 0;
        repeat (stall) begin
          @(negedge clk);
          if (pclk_s !== 1'b0 || en_s !== 1'b1) bad++;
        end
        check("stall_quiet", bad, 0);
        check("stall_no_edges", rises_s - r0, 0);
      end
      in_data_s  = (i == 0) ? b0 : b1;
      in_valid_s = 1'b1;
      k = 0;
      while (!in_ready_s && k < 2000) begin @(negedge clk); k++; end
      if (k >= 2000) check("accept_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
    end
    in_data_s = 8'h55;
    k = 0;
    while (done_s == d0 && k < 3000) begin @(negedge clk); k++; end
    if (k >= 3000) check("done_timeout", 0, 1);
    in_valid_s = 1'b0;
    @(negedge clk);
    check("busy_after_done", busy_s, 0);
    repeat (4) @(negedge clk);
    check("done_once", done_s - d0, 1);
  endtask

  initial begin
    int r0, n0, acc0, d0, k, t0;

    repeat (3) @(negedge clk);
    check("reset_outs_a", {a_busy, a_done, a_in_ready, a_out_valid, a_prog_clk,
                           a_prog_en, a_prog_in, a_out_data}, 0);
    check("reset_outs_b", {b_busy, b_done, b_in_ready, b_out_valid, b_prog_clk,
                           b_prog_en, b_prog_in, b_out_data}, 0);
    rst = 1'b0;
    @(negedge clk);

    // A: preloaded readback 0xBEEF, load A5,3C
    preload_a(16'hBEEF);
    r0 = a_rises; n0 = a_rbq.size(); acc0 = a_acc;
    run_load(8'hA5, 8'h3C, 0);
    check("a1_rises", a_rises - r0, 16);
    check("a1_chain", a_chain, 16'hA53C);
    check("a1_rb_count", a_rbq.size() - n0, 2);
    check("a1_rb0", a_rbq[n0], 8'hBE);
    check("a1_rb1", a_rbq[n0+1], 8'hEF);
    check("a1_accepted", a_acc - acc0, 2);

    // A: same data with a 5-cycle stall between bytes
    r0 = a_rises; n0 = a_rbq.size();
    run_load(8'hA5, 8'h3C, 5);
    check("a2_rises", a_rises - r0, 16);
    check("a2_chain", a_chain, 16'hA53C);
    check("a2_rb0", a_rbq[n0], 8'hA5);
    check("a2_rb1", a_rbq[n0+1], 8'h3C);

    // A: abort by reset after 5 rises, then a clean reload
    r0 = a_rises; d0 = a_done_n;
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    in_data_s = 8'h12; in_valid_s = 1'b1;
    k = 0;
    while ((a_rises - r0) < 5 && k < 200) begin @(negedge clk); k++; end
    check("abort_5_rises", a_rises - r0, 5);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outs", {a_prog_en, a_prog_clk, a_busy}, 3'b000);
    rst = 1'b0; in_valid_s = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_done", a_done_n - d0, 0);
    check("abort_chain", a_chain, 16'hA782);
    r0 = a_rises; n0 = a_rbq.size();
    run_load(8'h12, 8'h34, 0);
    check("a3_rises", a_rises - r0, 16);
    check("a3_chain", a_chain, 16'h1234);
    check("a3_rb0", a_rbq[n0], 8'hA7);
    check("a3_rb1", a_rbq[n0+1], 8'h82);
    check("a_rises_with_en", a_bad_en, 0);

    // B: 12-bit chain, CLK_DIV=3, partial trailing byte both directions
    @(negedge clk) sel = 1'b1;
    preload_b(12'hABC);
    r0 = b_rises; n0 = b_rbq.size(); acc0 = b_acc; t0 = b_rt.size();
    run_load(8'hFF, 8'hA0, 0);
    check("b_rises", b_rises - r0, 12);
    check("b_chain", b_chain, 12'hFFA);
    check("b_rb_count", b_rbq.size() - n0, 2);
    check("b_rb0", b_rbq[n0], 8'hAB);
    check("b_rb1", b_rbq[n0+1], 8'hC0);
    check("b_accepted", b_acc - acc0, 2);
    check("b_period", 32'(b_rt[t0+1] - b_rt[t0]), 60);
    check("b_prog_in_timing", b_viol, 0);
    check("b_rises_with_en", b_bad_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
